// File: rtl/security_pkg.sv
// security_pkg: shared state encoding and keypad command codes for the passcode controller
package security_pkg;
  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, UNLOCKED, LOCKOUT, PROGRAM} state_t;
  typedef logic [3:0] digit_t;
  localparam digit_t KEY_CLEAR = 4'hE;
  localparam digit_t KEY_ENTER = 4'hF;
  localparam digit_t KEY_PROG  = 4'hA;
endpackage

// File: rtl/passcode_controller_tick_timer.sv
// tick_timer: loadable down-counter stepped by the 1 Hz tick, saturating at zero
module tick_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expired
);
  logic [W-1:0] cnt;
  // a reload beats a same-cycle tick; the count never wraps below zero
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/passcode_controller.sv
// passcode_controller: keypad entry sequencer with timeout, unlock hold and lockout; CODE_PROGRAM_EN enables code reprogramming
module passcode_controller #(
  parameter int          CODE_LEN      = 4,
  parameter logic [31:0] DEFAULT_CODE  = 32'h1234,
  parameter int          MAX_FAILS     = 3,
  parameter int          ENTRY_TICKS   = 10,
  parameter int          UNLOCK_TICKS  = 5,
  parameter int          LOCKOUT_TICKS = 30
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [3:0]                         digit,
  input  logic                               valid,
  input  logic                               tick,
  output logic                               unlock,
  output logic                               alarm,
  output logic [3:0]                         entry_count,
  output logic [$clog2(MAX_FAILS+1)-1:0]     fail_count
);
  import security_pkg::*;
  localparam int AW = 4 * CODE_LEN;
  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TMAX = ENTRY_TICKS > UNLOCK_TICKS ?
    (ENTRY_TICKS > LOCKOUT_TICKS ? ENTRY_TICKS : LOCKOUT_TICKS) :
    (UNLOCK_TICKS > LOCKOUT_TICKS ? UNLOCK_TICKS : LOCKOUT_TICKS);
  localparam int TW = $clog2(TMAX + 1);
  state_t          state, state_n;
  logic [AW-1:0]   attempt, attempt_n, code;
  logic [3:0]      count, count_n;
  logic [FW-1:0]   fails, fails_n;
  logic            load, expired;
  logic [TW-1:0]   load_val;
  logic            is_digit, is_clr, is_ent, capture, full, match;
`ifdef CODE_PROGRAM_EN
  logic            is_prog, code_wr;
  assign is_prog = valid && digit == KEY_PROG;
`endif
  assign is_digit = valid && digit <= 4'd9;
  assign is_clr   = valid && digit == KEY_CLEAR;
  assign is_ent   = valid && digit == KEY_ENTER;
  assign full     = count == 4'(CODE_LEN);
  assign capture  = is_digit && count < 4'(CODE_LEN);
  assign match    = full && attempt == code;
  tick_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (tick),
    .expired  (expired)
  );
  // next-state, attempt capture, failure accounting and timer reloads
  always_comb begin
    state_n   = state;
    attempt_n = attempt;
    count_n   = count;
    fails_n   = fails;
    load      = 1'b0;
    load_val  = TW'(ENTRY_TICKS);
`ifdef CODE_PROGRAM_EN
    code_wr   = 1'b0;
`endif
    case (state)
      IDLE:
        if (is_digit) begin
          attempt_n = AW'(digit);
          count_n   = 4'd1;
          load      = 1'b1;
          state_n   = ENTRY;
        end
      ENTRY, PROGRAM:
        if (capture) begin
          attempt_n = AW'({attempt, digit});
          count_n   = count + 4'd1;
          load      = 1'b1;
        end else if (is_clr) state_n = IDLE;
        else if (is_ent) begin
          state_n = state == ENTRY ? CHECK : IDLE;
`ifdef CODE_PROGRAM_EN
          if (state == PROGRAM && full) begin
            code_wr = 1'b1;
            fails_n = '0;
          end
`endif
        end else if (expired) state_n = IDLE;
      CHECK:
        if (match) begin
          state_n  = UNLOCKED;
          fails_n  = '0;
          load     = 1'b1;
          load_val = TW'(UNLOCK_TICKS);
        end else begin
          fails_n  = fails + FW'(1);
          state_n  = fails_n == FW'(MAX_FAILS) ? LOCKOUT : IDLE;
          load     = fails_n == FW'(MAX_FAILS);
          load_val = TW'(LOCKOUT_TICKS);
        end
      UNLOCKED:
`ifdef CODE_PROGRAM_EN
        if (is_prog) begin
          state_n = PROGRAM;
          load    = 1'b1;
        end else if (expired) state_n = IDLE;
`else
        if (expired) state_n = IDLE;
`endif
      LOCKOUT:
        if (expired) begin
          state_n = IDLE;
          fails_n = '0;
        end
      default: state_n = IDLE;
    endcase
    if (state_n inside {IDLE, UNLOCKED, LOCKOUT}) begin
      attempt_n = '0;
      count_n   = '0;
    end
  end
  // state register with registered door and alarm drives
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      attempt <= '0;
      count   <= '0;
      fails   <= '0;
      unlock  <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state   <= state_n;
      attempt <= attempt_n;
      count   <= count_n;
      fails   <= fails_n;
      unlock  <= state_n == UNLOCKED;
      alarm   <= state_n == LOCKOUT;
    end
`ifdef CODE_PROGRAM_EN
  // stored code, rewritten only by a complete programming entry
  always_ff @(posedge clk or negedge reset)
    if (!reset) code <= AW'(DEFAULT_CODE);
    else if (code_wr) code <= attempt;
`else
  assign code = AW'(DEFAULT_CODE);
`endif
  assign entry_count = count;
  assign fail_count  = fails;
endmodule

// File: tb/tb_passcode_controller.sv
// tb_passcode_controller: directed scoreboard bench; expected output changes are queued with their arrival cycle
module tb_passcode_controller;
  import security_pkg::*;
  typedef struct {
    logic [7:0] v;
    int         at;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       unlock, alarm;
  logic [3:0] entry_count;
  logic [1:0] fail_count;
  int         cyc = 0;
  int         checks = 0;
  int         errs = 0;
  bit         run = 1'b0;
  bit         fin = 1'b0;
  bit         seen = 1'b0;
  bit         fin_done = 1'b0;
  logic [7:0] prev = 8'h00;
  exp_t       q[$];
  passcode_controller dut (
    .clk         (clk),
    .reset       (reset),
    .digit       (digit),
    .valid       (valid),
    .tick        (tick),
    .unlock      (unlock),
    .alarm       (alarm),
    .entry_count (entry_count),
    .fail_count  (fail_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every change on the outputs must match the next queued event at its cycle
  always @(negedge clk) begin
    automatic logic [7:0] cur = {unlock, alarm, fail_count, entry_count};
    automatic exp_t e;
    if (run) begin
      if (!seen) begin
        seen = 1'b1;
        checks++;
        if (cur !== 8'h00) begin
          errs++;
          $display("FAIL reset_state actual=%h required=00", cur);
        end
      end
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_change actual=%h@%0d required=%h", cur, cyc, prev);
        end else begin
          e = q.pop_front();
          if (cur !== e.v || cyc != e.at) begin
            errs++;
            $display("FAIL output_event actual=%h@%0d required=%h@%0d", cur, cyc, e.v, e.at);
          end
        end
        prev = cur;
      end
      if (fin && !fin_done) begin
        fin_done = 1'b1;
        checks++;
        if (q.size() != 0) begin
          errs++;
          $display("FAIL pending_events actual=%0d required=0 next=%h@%0d", q.size(), q[0].v, q[0].at);
        end
      end
    end
  end
  task automatic ex(input logic u, input logic a, input logic [1:0] f, input logic [3:0] e, input int lat);
    q.push_back('{v: {u, a, f, e}, at: cyc + lat});
  endtask
  task automatic key(input logic [3:0] d);
    valid = 1'b1;
    digit = d;
    @(negedge clk);
    valid = 1'b0;
  endtask
  task automatic dig(input logic [3:0] d, input logic [1:0] f, input logic [3:0] e);
    ex(1'b0, 1'b0, f, e, 1);
    key(d);
  endtask
  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask
  task automatic kt(input logic [3:0] d);
    valid = 1'b1;
    tick = 1'b1;
    digit = d;
    @(negedge clk);
    valid = 1'b0;
    tick = 1'b0;
  endtask
  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic open_code(input logic [15:0] c, input logic [1:0] f);
    dig(c[15:12], f, 1);
    dig(c[11:8], f, 2);
    dig(c[7:4], f, 3);
    dig(c[3:0], f, 4);
    ex(1'b1, 1'b0, 2'd0, 4'd0, 2);
    key(KEY_ENTER);
    wt(2);
  endtask
  task automatic hold_out;
    tk(4);
    ex(1'b0, 1'b0, 2'd0, 4'd0, 2);
    tk(1);
    wt(2);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    run = 1'b1;
    @(negedge clk);
    open_code(16'h1234, 2'd0);
    hold_out();
    for (int r = 0; r < 3; r++) begin
      dig(4'd1, 2'(r), 1);
      dig(4'd2, 2'(r), 2);
      dig(4'd3, 2'(r), 3);
      dig(4'd5, 2'(r), 4);
      if (r < 2) ex(1'b0, 1'b0, 2'(r + 1), 4'd0, 2);
      else ex(1'b0, 1'b1, 2'd3, 4'd0, 2);
      key(KEY_ENTER);
      wt(2);
    end
    key(4'd1);
    tk(29);
    key(4'd1);
    ex(1'b0, 1'b0, 2'd0, 4'd0, 2);
    tk(1);
    wt(2);
    dig(4'd1, 2'd0, 1);
    dig(4'd2, 2'd0, 2);
    ex(1'b0, 1'b0, 2'd1, 4'd0, 2);
    key(KEY_ENTER);
    wt(2);
    dig(4'd1, 2'd1, 1);
    dig(4'd2, 2'd1, 2);
    dig(4'd3, 2'd1, 3);
    dig(4'd4, 2'd1, 4);
    key(4'd9);
    ex(1'b1, 1'b0, 2'd0, 4'd0, 2);
    key(KEY_ENTER);
    wt(2);
    hold_out();
    dig(4'd1, 2'd0, 1);
    ex(1'b0, 1'b0, 2'd1, 4'd0, 2);
    key(KEY_ENTER);
    wt(2);
    dig(4'd1, 2'd1, 1);
    dig(4'd2, 2'd1, 2);
    tk(9);
    ex(1'b0, 1'b0, 2'd1, 4'd0, 2);
    tk(1);
    wt(2);
    dig(4'd1, 2'd1, 1);
    dig(4'd2, 2'd1, 2);
    ex(1'b0, 1'b0, 2'd1, 4'd0, 1);
    key(KEY_CLEAR);
    wt(1);
    dig(4'd1, 2'd1, 1);
    tk(9);
    ex(1'b0, 1'b0, 2'd1, 4'd2, 1);
    kt(4'd2);
    tk(9);
    dig(4'd3, 2'd1, 3);
    ex(1'b0, 1'b0, 2'd1, 4'd0, 1);
    key(KEY_CLEAR);
    wt(1);
    dig(4'd1, 2'd1, 1);
    dig(4'd2, 2'd1, 2);
    ex(1'b0, 1'b0, 2'd0, 4'd0, 1);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    open_code(16'h1234, 2'd0);
    hold_out();
`ifdef CODE_PROGRAM_EN
    open_code(16'h1234, 2'd0);
    ex(1'b0, 1'b0, 2'd0, 4'd0, 1);
    key(KEY_PROG);
    dig(4'd9, 2'd0, 1);
    dig(4'd8, 2'd0, 2);
    dig(4'd7, 2'd0, 3);
    dig(4'd6, 2'd0, 4);
    ex(1'b0, 1'b0, 2'd0, 4'd0, 1);
    key(KEY_ENTER);
    wt(2);
    dig(4'd1, 2'd0, 1);
    dig(4'd2, 2'd0, 2);
    dig(4'd3, 2'd0, 3);
    dig(4'd4, 2'd0, 4);
    ex(1'b0, 1'b0, 2'd1, 4'd0, 2);
    key(KEY_ENTER);
    wt(2);
    open_code(16'h9876, 2'd1);
    hold_out();
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    open_code(16'h1234, 2'd0);
    hold_out();
`endif
    wt(3);
    fin = 1'b1;
    wt(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
